// File: rtl/gigex_rx_cmd.sv
// gigex_rx_cmd
//
// Receive side of the GigEx byte-FIFO interface. Bytes arriving on one GigEx
// Rx channel are assembled MSB-first into CMD_LEN-bit command words. Each
// completed word is buffered and presented on one of NMODULES valid/ready
// command streams, selected by the word's top nibble (module id). The
// active-low nRF full flag for the channel is driven back to the GigEx.
//
// Parameters:
//   CMD_LEN    command word width (multiple of 8)
//   NMODULES   number of output command streams (max 16)
//   CHANNEL    GigEx Rx channel accepted (0-7)
//   FIFO_DEPTH total words held, head register included (power of 2, >= 4)
//   TIMEOUT    idle cycles inside a word before the partial word is discarded
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   Q[7:0]        Rx data byte
//   nRx           Rx byte valid, active low
//   RC[2:0]       Rx channel of the current byte
//   nRF[7:0]      per-channel Rx full flag, active low (0 = full)
//   out_data      head word, broadcast to all modules
//   out_valid     one-hot, bit i = head word is for module i
//   out_ready     per-module ready
//   err_timeout   pulse: partial word discarded after idle timeout
//   err_module    pulse: word with illegal module id dropped
//   err_overflow  pulse: completed word dropped, buffer full
//
// Optional build macro GIGEX_RX_STATS_EN adds:
//   stat_clr         synchronous clear of both statistics counters
//   stat_words[31:0] number of words popped
//   stat_drops[15:0] number of dropped words/partials, saturating

module gigex_rx_cmd #(
    parameter int CMD_LEN    = 32,
    parameter int NMODULES   = 4,
    parameter int CHANNEL    = 0,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          Q,
    input  logic                nRx,
    input  logic [2:0]          RC,
    output logic [7:0]          nRF,
    output logic [CMD_LEN-1:0]  out_data,
    output logic [NMODULES-1:0] out_valid,
    input  logic [NMODULES-1:0] out_ready,
    output logic                err_timeout,
    output logic                err_module,
    output logic                err_overflow
`ifdef GIGEX_RX_STATS_EN
    ,
    input  logic                stat_clr,
    output logic [31:0]         stat_words,
    output logic [15:0]         stat_drops
`endif
);

    localparam int NBYTES = CMD_LEN / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;

    // ------------------------------------------------------------------
    // Byte assembly
    // ------------------------------------------------------------------
    logic               accept;
    logic               last_byte;
    logic               idle_expire;
    logic [BCW-1:0]     byte_cnt;
    logic [TW-1:0]      idle_cnt;
    logic [CMD_LEN-1:0] asm_word;
    logic [CMD_LEN-1:0] asm_next;

    // Completed word, held for one cycle while it is classified and written
    logic               cmp_valid;
    logic [CMD_LEN-1:0] cmp_word;
    logic [3:0]         cmp_id;
    logic               cmp_legal;

    assign accept    = !nRx && (RC == 3'(CHANNEL));
    assign last_byte = (byte_cnt == BCW'(NBYTES - 1));

    // The idle counter never exceeds TIMEOUT-1, so the edge on which it would
    // reach TIMEOUT is the discard edge. An accepted byte on that edge wins.
    assign idle_expire = !accept && (byte_cnt != '0) && (idle_cnt == TW'(TIMEOUT - 1));

    // Insert the incoming byte into the lane selected by the byte counter,
    // first byte in the top lane.
    always_comb begin
        asm_next = asm_word;
        for (int b = 0; b < NBYTES; b++) begin
            if (byte_cnt == BCW'(b)) begin
                asm_next[CMD_LEN-1-8*b -: 8] = Q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            asm_word    <= '0;
            cmp_valid   <= 1'b0;
            cmp_word    <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            cmp_valid   <= 1'b0;
            if (accept) begin
                idle_cnt <= '0;
                asm_word <= asm_next;
                if (last_byte) begin
                    byte_cnt  <= '0;
                    cmp_word  <= asm_next;
                    cmp_valid <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end else if (byte_cnt != '0) begin
                if (idle_expire) begin
                    byte_cnt    <= '0;
                    idle_cnt    <= '0;
                    err_timeout <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Word buffer: RAM plus a registered head stage. A word written to the
    // RAM is moved into the head register on the following edge, which gives
    // the two-cycle byte-to-valid latency and registered outputs.
    // ------------------------------------------------------------------
    logic [CMD_LEN-1:0] mem_data [FIFO_DEPTH];
    logic [3:0]         mem_id   [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      mem_count;
    logic               head_valid;
    logic [CW-1:0]      occ;
    logic [CW-1:0]      occ_next;
    logic               full;
    logic               pop;
    logic               push_req;
    logic               push;
    logic               load;
    logic [7:0]         nrf_next;

    assign cmp_id     = cmp_word[CMD_LEN-1 -: 4];
    assign cmp_legal  = ({1'b0, cmp_id} < 5'(NMODULES));
    assign head_valid = |out_valid;
    assign pop        = |(out_valid & out_ready);
    assign occ        = mem_count + CW'(head_valid);
    assign full       = (occ == CW'(FIFO_DEPTH));
    assign push_req   = cmp_valid && cmp_legal;
    // A pop on the same edge frees the slot a push into a full buffer needs
    assign push       = push_req && (!full || pop);
    assign load       = (mem_count != '0) && (!head_valid || pop);
    assign occ_next   = occ + CW'(push) - CW'(pop);

    // Keep one slot spare: nRF drops once the next occupancy would leave
    // fewer than two free entries.
    always_comb begin
        nrf_next          = 8'h00;
        nrf_next[CHANNEL] = (occ_next <= CW'(FIFO_DEPTH - 2));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= cmp_word;
            mem_id[wr_ptr]   <= cmp_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            mem_count    <= '0;
            out_valid    <= '0;
            out_data     <= '0;
            err_module   <= 1'b0;
            err_overflow <= 1'b0;
            nRF          <= 8'h00;
        end else begin
            err_module   <= cmp_valid && !cmp_legal;
            err_overflow <= push_req && !push;
            nRF          <= nrf_next;
            mem_count    <= mem_count + CW'(push) - CW'(load);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                out_data  <= mem_data[rd_ptr];
                out_valid <= NMODULES'(1) << mem_id[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
            end else if (pop) begin
                out_valid <= '0;
            end
        end
    end

`ifdef GIGEX_RX_STATS_EN
    // ------------------------------------------------------------------
    // Statistics counters
    // ------------------------------------------------------------------
    logic [1:0]  drop_events;
    logic [16:0] drops_sum;

    assign drop_events = {1'b0, err_timeout} + {1'b0, err_module} + {1'b0, err_overflow};
    assign drops_sum   = {1'b0, stat_drops} + 17'(drop_events);

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_words <= '0;
            stat_drops <= '0;
        end else begin
            if (pop) begin
                stat_words <= stat_words + 1'b1;
            end
            stat_drops <= drops_sum[16] ? 16'hFFFF : drops_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_gigex_rx_cmd.sv
// Directed self-checking bench for gigex_rx_cmd (default parameters).
module tb_gigex_rx_cmd;

    localparam int CMD_LEN    = 32;
    localparam int NMODULES   = 4;
    localparam int CHANNEL    = 0;
    localparam int FIFO_DEPTH = 8;
    localparam int TIMEOUT    = 255;

    logic                clk = 1'b0;
    logic                rst;
    logic [7:0]          Q;
    logic                nRx;
    logic [2:0]          RC;
    logic [7:0]          nRF;
    logic [CMD_LEN-1:0]  out_data;
    logic [NMODULES-1:0] out_valid;
    logic [NMODULES-1:0] out_ready;
    logic                err_timeout;
    logic                err_module;
    logic                err_overflow;
`ifdef GIGEX_RX_STATS_EN
    logic                stat_clr = 1'b0;
    logic [31:0]         stat_words;
    logic [15:0]         stat_drops;
`endif

    int errors = 0;
    int checks = 0;
    int n_timeout = 0;
    int n_module = 0;
    int n_overflow = 0;
    logic [31:0] pop_data [$];
    logic [3:0]  pop_valid [$];

    gigex_rx_cmd #(
        .CMD_LEN(CMD_LEN), .NMODULES(NMODULES), .CHANNEL(CHANNEL),
        .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .Q(Q), .nRx(nRx), .RC(RC), .nRF(nRF),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .err_timeout(err_timeout), .err_module(err_module), .err_overflow(err_overflow)
`ifdef GIGEX_RX_STATS_EN
        , .stat_clr(stat_clr), .stat_words(stat_words), .stat_drops(stat_drops)
`endif
    );

    always #5 clk = ~clk;

    // Count error pulses and record every pop, sampled mid-cycle
    always @(negedge clk) begin
        if (err_timeout)  n_timeout++;
        if (err_module)   n_module++;
        if (err_overflow) n_overflow++;
        if (!rst && |(out_valid & out_ready)) begin
            pop_data.push_back(out_data);
            pop_valid.push_back(out_valid);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [2:0] ch, input logic [7:0] b);
        RC  = ch;
        Q   = b;
        nRx = 1'b0;
        tick(1);
        nRx = 1'b1;
        RC  = 3'd0;
        Q   = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(3'(CHANNEL), w[31-8*i -: 8]);
    endtask

    function automatic logic [31:0] wd(input int i);
        return {4'(i % 4), 20'hA5000, 8'(i)};
    endfunction

    task automatic test_reset;
        rst = 1'b1; nRx = 1'b1; Q = 8'h00; RC = 3'd0; out_ready = '1;
        tick(3);
        checks++;
        if (nRF !== 8'h00) begin errors++; $display("[TB] FAIL reset_nRF: got %h expected 00", nRF); end
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0000", out_valid); end
        checks++;
        if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00000000", out_data); end
        checks++;
        if ({err_timeout, err_module, err_overflow} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_err: got %b expected 000", {err_timeout, err_module, err_overflow});
        end
        rst = 1'b0;
        tick(1);
        checks++;
        if (nRF !== 8'h01) begin errors++; $display("[TB] FAIL release_nRF: got %h expected 01", nRF); end
    endtask

    task automatic test_basic;
        out_ready = '1;
        send_word(32'h20ABCDEF);
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("[TB] FAIL basic_lat0: got %b expected 0000", out_valid); end
        tick(1);
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("[TB] FAIL basic_lat1: got %b expected 0000", out_valid); end
        tick(1);
        checks++;
        if (out_valid !== 4'b0100) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 0100", out_valid); end
        checks++;
        if (out_data !== 32'h20ABCDEF) begin errors++; $display("[TB] FAIL basic_data: got %h expected 20abcdef", out_data); end
        tick(1);
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("[TB] FAIL basic_pop: got %b expected 0000", out_valid); end
    endtask

    task automatic test_interleave;
        pop_data.delete(); pop_valid.delete();
        send_byte(3'(CHANNEL), 8'h10);
        send_byte(3'd3, 8'hFF);
        send_byte(3'(CHANNEL), 8'h11);
        send_byte(3'd3, 8'hFF);
        send_byte(3'(CHANNEL), 8'h12);
        send_byte(3'd3, 8'hFF);
        send_byte(3'(CHANNEL), 8'h13);
        tick(2);
        checks++;
        if (out_valid !== 4'b0010) begin errors++; $display("[TB] FAIL ilv_valid: got %b expected 0010", out_valid); end
        checks++;
        if (out_data !== 32'h10111213) begin errors++; $display("[TB] FAIL ilv_data: got %h expected 10111213", out_data); end
        tick(3);
        checks++;
        if (pop_data.size() != 1) begin errors++; $display("[TB] FAIL ilv_count: got %0d words expected 1", pop_data.size()); end
    endtask

    task automatic test_timeout;
        int t0;
        t0 = n_timeout;
        send_byte(3'(CHANNEL), 8'h00);
        send_byte(3'(CHANNEL), 8'h01);
        tick(TIMEOUT);
        checks++;
        if (err_timeout !== 1'b1) begin errors++; $display("[TB] FAIL to_pulse: got %b expected 1", err_timeout); end
        send_word(32'h30000005);
        checks++;
        if (n_timeout - t0 != 1) begin errors++; $display("[TB] FAIL to_count: got %0d expected 1", n_timeout - t0); end
        tick(2);
        checks++;
        if (out_valid !== 4'b1000) begin errors++; $display("[TB] FAIL to_valid: got %b expected 1000", out_valid); end
        checks++;
        if (out_data !== 32'h30000005) begin errors++; $display("[TB] FAIL to_data: got %h expected 30000005", out_data); end
        tick(1);
    endtask

    task automatic test_timeout_boundary;
        int t0;
        t0 = n_timeout;
        send_byte(3'(CHANNEL), 8'h00);
        send_byte(3'(CHANNEL), 8'h01);
        tick(TIMEOUT - 1);
        send_byte(3'(CHANNEL), 8'h02);
        send_byte(3'(CHANNEL), 8'h03);
        checks++;
        if (n_timeout != t0) begin errors++; $display("[TB] FAIL tob_count: got %0d expected 0", n_timeout - t0); end
        tick(2);
        checks++;
        if (out_valid !== 4'b0001) begin errors++; $display("[TB] FAIL tob_valid: got %b expected 0001", out_valid); end
        checks++;
        if (out_data !== 32'h00010203) begin errors++; $display("[TB] FAIL tob_data: got %h expected 00010203", out_data); end
        tick(1);
    endtask

    task automatic test_bad_module;
        int m0;
        m0 = n_module;
        send_word(32'h50000000);
        tick(1);
        checks++;
        if (err_module !== 1'b1) begin errors++; $display("[TB] FAIL mod_pulse: got %b expected 1", err_module); end
        tick(1);
        checks++;
        if (err_module !== 1'b0) begin errors++; $display("[TB] FAIL mod_pulse_end: got %b expected 0", err_module); end
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("[TB] FAIL mod_valid: got %b expected 0000", out_valid); end
        tick(2);
        checks++;
        if (n_module - m0 != 1) begin errors++; $display("[TB] FAIL mod_count: got %0d expected 1", n_module - m0); end
    endtask

    task automatic test_overflow;
        int o0;
        o0 = n_overflow;
        out_ready = '0;
        pop_data.delete(); pop_valid.delete();
        for (int i = 0; i < 7; i++) send_word(wd(i));
        checks++;
        if (nRF[CHANNEL] !== 1'b1) begin errors++; $display("[TB] FAIL ovf_nrf6: got %b expected 1", nRF[CHANNEL]); end
        tick(1);
        checks++;
        if (nRF[CHANNEL] !== 1'b0) begin errors++; $display("[TB] FAIL ovf_nrf7: got %b expected 0", nRF[CHANNEL]); end
        send_word(wd(7));
        tick(2);
        checks++;
        if (n_overflow != o0) begin errors++; $display("[TB] FAIL ovf_early: got %0d expected 0", n_overflow - o0); end
        send_word(wd(8));
        tick(1);
        checks++;
        if (err_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_pulse: got %b expected 1", err_overflow); end
        out_ready = '1;
        tick(14);
        checks++;
        if (pop_data.size() != 8) begin errors++; $display("[TB] FAIL ovf_drain_count: got %0d expected 8", pop_data.size()); end
        for (int i = 0; i < 8 && i < pop_data.size(); i++) begin
            checks++;
            if (pop_data[i] !== wd(i) || pop_valid[i] !== 4'(1 << (i % 4))) begin
                errors++;
                $display("[TB] FAIL ovf_drain_%0d: got %h/%b expected %h/%b", i, pop_data[i], pop_valid[i], wd(i), 4'(1 << (i % 4)));
            end
        end
        checks++;
        if (nRF[CHANNEL] !== 1'b1) begin errors++; $display("[TB] FAIL ovf_nrf_free: got %b expected 1", nRF[CHANNEL]); end
    endtask

    task automatic test_full_push_pop;
        int o0;
        o0 = n_overflow;
        out_ready = '0;
        for (int i = 0; i < 8; i++) send_word(wd(10 + i));
        tick(2);
        pop_data.delete(); pop_valid.delete();
        send_word(wd(18));
        out_ready = '1;
        tick(1);
        checks++;
        if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL fpp_pulse: got %b expected 0", err_overflow); end
        tick(14);
        checks++;
        if (pop_data.size() != 9) begin errors++; $display("[TB] FAIL fpp_count: got %0d expected 9", pop_data.size()); end
        for (int i = 0; i < 9 && i < pop_data.size(); i++) begin
            checks++;
            if (pop_data[i] !== wd(10 + i)) begin
                errors++; $display("[TB] FAIL fpp_word_%0d: got %h expected %h", i, pop_data[i], wd(10 + i));
            end
        end
        checks++;
        if (n_overflow != o0) begin errors++; $display("[TB] FAIL fpp_ovf: got %0d expected 0", n_overflow - o0); end
    endtask

    task automatic test_back_to_back_hol;
        out_ready = 4'b1110;
        pop_data.delete(); pop_valid.delete();
        send_word(32'h0AAA0001);
        send_word(32'h2BBB0002);
        tick(4);
        checks++;
        if (out_valid !== 4'b0001) begin errors++; $display("[TB] FAIL hol_valid: got %b expected 0001", out_valid); end
        checks++;
        if (out_data !== 32'h0AAA0001) begin errors++; $display("[TB] FAIL hol_data: got %h expected 0aaa0001", out_data); end
        checks++;
        if (pop_data.size() != 0) begin errors++; $display("[TB] FAIL hol_stall: got %0d pops expected 0", pop_data.size()); end
        out_ready = '1;
        tick(4);
        checks++;
        if (pop_data.size() != 2) begin errors++; $display("[TB] FAIL hol_count: got %0d expected 2", pop_data.size()); end
        else begin
            checks++;
            if (pop_data[0] !== 32'h0AAA0001 || pop_valid[0] !== 4'b0001) begin
                errors++; $display("[TB] FAIL hol_first: got %h/%b expected 0aaa0001/0001", pop_data[0], pop_valid[0]);
            end
            checks++;
            if (pop_data[1] !== 32'h2BBB0002 || pop_valid[1] !== 4'b0100) begin
                errors++; $display("[TB] FAIL hol_second: got %h/%b expected 2bbb0002/0100", pop_data[1], pop_valid[1]);
            end
        end
    endtask

    task automatic test_reset_midword;
        int e0;
        out_ready = '0;
        send_word(32'h30000077);
        send_byte(3'(CHANNEL), 8'h12);
        send_byte(3'(CHANNEL), 8'h34);
        tick(1);
        e0 = n_timeout + n_module + n_overflow;
        rst = 1'b1;
        tick(2);
        checks++;
        if (out_valid !== 4'b0000 || nRF !== 8'h00) begin
            errors++; $display("[TB] FAIL rmw_state: got %b/%h expected 0000/00", out_valid, nRF);
        end
        rst = 1'b0;
        out_ready = '1;
        tick(1);
        pop_data.delete(); pop_valid.delete();
        send_word(32'h10000042);
        tick(2);
        checks++;
        if (out_valid !== 4'b0010) begin errors++; $display("[TB] FAIL rmw_valid: got %b expected 0010", out_valid); end
        checks++;
        if (out_data !== 32'h10000042) begin errors++; $display("[TB] FAIL rmw_data: got %h expected 10000042", out_data); end
        tick(3);
        checks++;
        if (pop_data.size() != 1) begin errors++; $display("[TB] FAIL rmw_count: got %0d expected 1", pop_data.size()); end
        checks++;
        if (n_timeout + n_module + n_overflow != e0) begin
            errors++; $display("[TB] FAIL rmw_err: got %0d expected 0", n_timeout + n_module + n_overflow - e0);
        end
    endtask

    initial begin
        $display("[TB] starting gigex_rx_cmd bench");
        test_reset;
        test_basic;
        test_interleave;
        test_timeout;
        test_timeout_boundary;
        test_bad_module;
        test_overflow;
        test_full_push_pop;
        test_back_to_back_hol;
        test_reset_midword;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gigex_rx_cmd.md
Name: gigex_rx_cmd

Overview:
Receive side of the GigEx byte-FIFO interface. It takes the Rx byte stream (Q/nRx/RC) from one GigEx channel and assembles MSB-first bytes into CMD_LEN-bit command words. Completed words are buffered and routed to one of NMODULES per-module valid/ready command streams, which feed the per-module rst_controller/data_tx command inputs. It also drives the active-low nRF full flags back to the GigEx.

Parameters:
CMD_LEN, 32, command word width; must be a multiple of 8
NMODULES, 4, number of output command streams (max 16)
CHANNEL, 0, GigEx Rx channel accepted (0-7)
FIFO_DEPTH, 8, word buffer depth; power of 2, >= 4
TIMEOUT, 255, maximum idle cycles between bytes of one word before the partial word is discarded

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
Q  in  8  Rx data byte from GigEx
nRx  in  1  Rx byte valid, active low; Q is sampled on the rising clk edge when nRx=0
RC  in  3  Rx channel of the current byte
nRF  out  8  per-channel Rx full flag to GigEx, active low (0 = full)
out_data  out  CMD_LEN  head word, broadcast to all modules
out_valid  out  NMODULES  one-hot; bit i = head word is destined for module i
out_ready  in  NMODULES  per-module ready
err_timeout  out  1  one-cycle pulse: partial word discarded
err_module  out  1  one-cycle pulse: word with an illegal module id dropped
err_overflow  out  1  one-cycle pulse: completed word dropped because the buffer was full

Behaviour:
- Reset values: nRF=8'h00, out_valid=0, out_data=0, all err_* = 0, byte counter=0, buffer empty, timeout counter=0.
- Byte acceptance: a byte is accepted when nRx=0 and RC=CHANNEL. If nRx=0 and RC!=CHANNEL, the byte is ignored and the assembly state is unchanged.
- Assembly:
  - The first accepted byte of a word goes to [CMD_LEN-1:CMD_LEN-8], the next byte to the next lower 8 bits, and so on.
  - The byte counter wraps at CMD_LEN/8.
  - On the edge that accepts the final byte, the word is complete.
- Timeout:
  - The counter clears on each accepted byte and increments while the byte counter != 0 and no byte is accepted.
  - When the counter reaches TIMEOUT: byte counter and counter clear, and err_timeout pulses on the next cycle.
  - A byte accepted in the same cycle the counter reaches TIMEOUT wins: no discard.
- Module id = word[CMD_LEN-1:CMD_LEN-4].
  - If id >= NMODULES, the word is not written and err_module pulses one cycle after completion.
- Buffer write:
  - A completed, legal word is written on the edge after completion.
  - out_valid[id] asserts on the following edge, i.e. 2 cycles after the final byte is sampled.
  - If the buffer is full at the write, the word is dropped and err_overflow pulses.
- Buffer read:
  - Head word pops when (out_valid & out_ready) != 0.
  - The id field is stored with the word; out_valid is one-hot on the head word's id, or all 0 when empty.
  - Head-of-line blocking is intended: the head waits for its own module's ready, and other modules do not bypass it.
  - Simultaneous push and pop when full: the pop frees a slot and the push succeeds, with no overflow.
  - Pop when empty is impossible, since out_valid=0.
- Flow control:
  - nRF is registered.
  - nRF[CHANNEL] = 1 when occupancy <= FIFO_DEPTH-2 (next-state occupancy); otherwise 0.
  - All other nRF bits are held at 0.
  - GigEx may deliver up to 3 bytes after nRF falls; the one-slot margin absorbs at most one completing word, so overflow occurs only on a GigEx protocol violation.
- Reset mid-word or with a non-empty buffer: all contents are discarded and no err pulses are generated.

Optional Feature:
Macro GIGEX_RX_STATS_EN.
- Defined:
  - Adds outputs stat_words (32) and stat_drops (16).
  - stat_words counts words popped.
  - stat_drops counts err_timeout + err_module + err_overflow events, saturating at 16'hFFFF; simultaneous events add their count.
  - Adds input stat_clr (1), a synchronous clear for both counters; an event in the same cycle as the clear is lost.
  - Both counters reset to 0 on rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, all out_ready=1, send bytes 20 AB CD EF on CHANNEL with 0 gaps -> out_valid=4'b0100 and out_data=32'h20ABCDEF exactly 2 cycles after the 4th byte; word pops the next cycle.
- Interleave RC=3 bytes FF FF between CHANNEL bytes 10 11 12 13 -> single word 32'h10111213 to module 1; RC=3 bytes ignored.
- Send bytes 00 01, idle TIMEOUT cycles, then send 30 00 00 05 -> err_timeout pulses once; next word 32'h30000005 delivered to module 3.
- Word 32'h50000000 (id 5) -> err_module pulse; out_valid stays 0.
- out_ready=0, send 8 legal words -> nRF[CHANNEL] falls after the 7th write is committed; a 9th word sent after nRF falls -> err_overflow; release ready -> 8 words drain in order.
- Head word for module 0, out_ready=4'b1110 -> head stalls and the module 2 word behind it is not presented; raising out_ready[0] pops both in order.
